// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Holds the FSM state encoding, default bus widths and the word-alignment check.
package mem_stage_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } stateT;

    function automatic logic isAligned(input logic [1:0] lowBits);
        return (lowBits & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage controller and the memory.
// The controller side is the master; the memory model or SRAM wrapper is the slave.
interface mem_stage_ctrl_if
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: launches one word access per load/store, stalls the
// pipeline until the memory acknowledges, and returns load data to MEM/WB.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              misalign_o,
    mem_stage_ctrl_if.master  memBus
);

    stateT             state;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;

    logic access;
    logic aligned;
    logic accept;

    // Nothing is accepted while reset is held, so stall/misalign drop with it.
    assign access     = ~rst_i & start_i & (MemRead_i | MemWrite_i);
    assign aligned    = isAligned(addr_i[1:0]);
    assign accept     = (state == IDLE) & access & aligned;
    assign stall_o    = accept | (state == REQ);
    assign misalign_o = (state == IDLE) & access & ~aligned;

    assign memBus.mem_req_o   = memReq;
    assign memBus.mem_we_o    = memWe;
    assign memBus.mem_addr_o  = memAddr;
    assign memBus.mem_wdata_o = memWdata;

    // NOTE: non-blocking assignments throughout so every register samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            rdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // A combined read+write request is serviced as a store.
                        memAddr  <= addr_i;
                        memWdata <= wdata_i;
                        memWe    <= MemWrite_i;
                        memReq   <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (memBus.mem_ack_i) begin
                        memReq <= 1'b0;
                        if (!memWe) begin
                            rdata_o <= memBus.mem_rdata_i;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // EX/MEM advances at this edge; the held instruction is not re-issued.
                    state <= IDLE;
                end
                default: begin
                    memReq <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
